uart_byte_receiver: RTL and testbench

Receive side of the system's 8N1 UART serial link. Samples the asynchronous `rxd` line at mid-bit, assembles LSB-first bytes and presents each byte to the CPU-side peripheral logic through a one-entry valid/acknowledge holding register. Detects false starts, framing errors and overrun. Default timing is 9600 baud from a 50 MHz `sysclk`, which gives 5208 clocks per bit.

---
 rtl/uart_byte_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_byte_receiver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, one-entry
// valid/ack holding register with false-start, framing and overrun detection.
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [1:0]      sync_reg;
  logic            rxs;
  logic            rxs_d_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      idx_reg;
  logic [7:0]      sh_reg;

  logic            start_edge;
  logic            cnt_half;
  logic            cnt_full;
  logic            data_sample;
  logic            stop_sample;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      sync_reg  <= 2'b11;
      rxs_d_reg <= 1'b1;
    end else begin
      sync_reg  <= {sync_reg[0], rxd};
      rxs_d_reg <= rxs;
    end
  end

  assign rxs        = sync_reg[1];
  assign start_edge = rxs_d_reg & ~rxs;
  assign cnt_half   = (cnt_reg == HALF_LAST);
  assign cnt_full   = (cnt_reg == BIT_LAST);

  // FSM state register
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_edge) state_next = START;
      START:   if (cnt_half) state_next = rxs ? IDLE : DATA;
      DATA:    if (cnt_full && (idx_reg == 3'd7)) state_next = STOP;
      STOP:    if (cnt_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and sample strobes
  always_comb begin
    busy        = (state_reg != IDLE);
    data_sample = (state_reg == DATA) && cnt_full;
    stop_sample = (state_reg == STOP) && cnt_full;
  end

  // Bit timing counter, bit index and shift register
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      cnt_reg <= '0;
      idx_reg <= 3'd0;
      sh_reg  <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
        end
        START: begin
          if (cnt_half) begin
            cnt_reg <= '0;
            idx_reg <= 3'd0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (data_sample) begin
            sh_reg  <= {rxs, sh_reg[7:1]};
            cnt_reg <= '0;
            idx_reg <= idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        STOP: begin
          if (cnt_full) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

  // Holding register: an ack in the stop-sample cycle frees the slot first,
  // so a colliding new byte is loaded rather than counted as an overrun.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= stop_sample & ~rxs;
      if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (stop_sample && rxs) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= sh_reg;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at a short bit period; every
// expected value below is hand-derived from the frame timing.
module tb_uart_byte_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + 1 + HALF + 9 * CPB;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       rxd    = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_errs   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  // Running tallies of frame_err and rx_overrun high cycles.
  always @(negedge sysclk) begin
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (rx_overrun) ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("check %s: got 0x%0h exp 0x%0h ok", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  task automatic wait_and_ack(input string tag, input logic [7:0] exp, input int budget);
    int n;
    n = 0;
    while (!rx_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, (n >= budget), 0);
    check({tag, "_data"}, rx_data, exp);
    ack_pulse();
    check({tag, "_cleared"}, rx_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    int ov0;
    int cyc;
    int busy_n;

    // Reset
    reset = 1'b0; rxd = 1'b1; rx_ack = 1'b0;
    repeat (2) tick();
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (4) tick();
    check("rel_valid", rx_valid, 0);
    check("rel_busy", busy, 0);

    // Single byte 0xB9 with latency measured from the rxd fall
    cyc = 0;
    fork
      send_frame(8'hB9, 1'b1);
      begin
        while (!rx_valid && cyc < LAT + 20) begin
          tick();
          cyc++;
        end
      end
    join
    $display("info single byte latency %0d cycles (nominal %0d)", cyc, LAT);
    check("single_latency_in_window", (cyc >= LAT - 1) && (cyc <= LAT + 1), 1);
    repeat (20) tick();
    check("single_held_valid", rx_valid, 1);
    check("single_data", rx_data, 8'hB9);
    ack_pulse();
    check("single_ack_valid", rx_valid, 0);
    check("single_ack_overrun", rx_overrun, 0);

    // Back-to-back 0x96, 0x1E with prompt acks
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      begin
        send_frame(8'h96, 1'b1);
        send_frame(8'h1E, 1'b1);
      end
      begin
        wait_and_ack("b2b_first", 8'h96, 400);
        wait_and_ack("b2b_second", 8'h1E, 400);
      end
    join
    repeat (2) tick();
    check("b2b_overrun_cycles", ov_cnt - ov0, 0);
    check("b2b_frame_err_cycles", fe_cnt - fe0, 0);

    // False start: low for 4 cycles, sampled high at mid start bit
    busy_n = 0;
    rxd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rxd = 1'b1;
      tick();
      if (busy) busy_n++;
    end
    check("false_busy_cycles", busy_n, HALF);
    check("false_valid", rx_valid, 0);
    check("false_idle", busy, 0);
    send_frame(8'h1E, 1'b1);
    check("after_false_valid", rx_valid, 1);
    check("after_false_data", rx_data, 8'h1E);
    ack_pulse();

    // Framing error, then line held low must not retrigger
    fe0 = fe_cnt;
    send_frame(8'hB9, 1'b0);
    repeat (3 * CPB) tick();
    check("ferr_pulse_cycles", fe_cnt - fe0, 1);
    check("ferr_valid", rx_valid, 0);
    check("ferr_data_kept", rx_data, 8'h1E);
    check("ferr_low_no_retrigger", busy, 0);
    rxd = 1'b1;
    repeat (CPB) tick();
    send_frame(8'h96, 1'b1);
    check("after_ferr_valid", rx_valid, 1);
    check("after_ferr_data", rx_data, 8'h96);
    ack_pulse();

    // Overrun: two frames with no ack
    send_frame(8'h96, 1'b1);
    send_frame(8'h1E, 1'b1);
    repeat (4) tick();
    check("ovr_data_kept", rx_data, 8'h96);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", rx_overrun, 1);
    ack_pulse();
    check("ovr_ack_valid", rx_valid, 0);
    check("ovr_ack_flag", rx_overrun, 0);

    // Ack on the same edge as the second frame's stop sample
    send_frame(8'h96, 1'b1);
    fork
      send_frame(8'h1E, 1'b1);
      begin
        repeat (LAT - 1) tick();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
      end
    join
    check("coll_data", rx_data, 8'h1E);
    check("coll_valid", rx_valid, 1);
    check("coll_overrun", rx_overrun, 0);
    ack_pulse();
    check("coll_ack_valid", rx_valid, 0);

    // Reset in the middle of data bit 4 of 0xF0 (line stays high after)
    fe0 = fe_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * CPB + HALF) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        check("midrst_busy", busy, 0);
      end
    join
    repeat (4) tick();
    check("midrst_valid", rx_valid, 0);
    check("midrst_frame_err", fe_cnt - fe0, 0);
    check("midrst_data", rx_data, 8'h00);
    send_frame(8'h5A, 1'b1);
    check("after_rst_valid", rx_valid, 1);
    check("after_rst_data", rx_data, 8'h5A);
    ack_pulse();
    check("after_rst_ack", rx_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
